// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU-side arithmetic helpers.
package alu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    localparam int CHUNK = 4;

    typedef logic [2:0] nzp_t;
    localparam nzp_t NZP_N = 3'b100;
    localparam nzp_t NZP_Z = 3'b010;
    localparam nzp_t NZP_P = 3'b001;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice. Purely combinational.
// Group propagate/generate are exported so a wider adder can chain slices.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Every carry is formed directly from the g/p terms; no ripple path.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
        c[4] = gg | (pg & cin);
        s    = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: D = A - B computed as A + ~B + 1, one nibble per
// clock LSB first, with borrow, signed-overflow and NZP flags.
module nibble_serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             borrow,
    output logic             overflow,
    output nzp_t             nzp
);

    localparam int NSTEPS = WIDTH / CHUNK;
    localparam int SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

    sub_state_t       state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bn_q, bn_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    nzp_t             nzp_q, nzp_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] sum_nib;
    logic             slice_cout;
    logic             slice_pg;
    logic             slice_gg;
    logic [WIDTH-1:0] d_fin;
    logic             accept;
    logic             last_step;

    cla4_slice u_slice (
        .a   (a_q[step_q*CHUNK +: CHUNK]),
        .b   (bn_q[step_q*CHUNK +: CHUNK]),
        .cin (carry_q),
        .s   (sum_nib),
        .cout(slice_cout),
        .pg  (slice_pg),
        .gg  (slice_gg)
    );

    assign accept    = in_valid && in_ready;
    assign last_step = (step_q == LAST_STEP);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                 state_d = RUN;
            RUN:     if (last_step)              state_d = DONE;
            DONE:    if (out_valid_q && out_ready) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // FSM outputs: operands are only taken while idle.
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Datapath next values: operand latch, nibble step, flags on the last step.
    always_comb begin
        a_d         = a_q;
        bn_d        = bn_q;
        d_d         = d_q;
        step_d      = step_q;
        carry_d     = carry_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        nzp_d       = nzp_q;
        out_valid_d = out_valid_q;
        d_fin       = d_q;
        d_fin[step_q*CHUNK +: CHUNK] = sum_nib;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = A;
                    bn_d    = ~B;
                    d_d     = '0;
                    step_d  = '0;
                    carry_d = 1'b1;
                end
            end
            RUN: begin
                d_d     = d_fin;
                step_d  = step_q + SW'(1);
                // Lookahead form of the slice carry-out.
                carry_d = slice_gg | (slice_pg & carry_q);
                if (last_step) begin
                    borrow_d    = ~slice_cout;
                    // Operand signs differ (a vs ~b equal) and result sign flipped.
                    ovf_d       = (a_q[WIDTH-1] == bn_q[WIDTH-1]) &&
                                  (d_fin[WIDTH-1] != a_q[WIDTH-1]);
                    if (d_fin[WIDTH-1])   nzp_d = NZP_N;
                    else if (d_fin == '0) nzp_d = NZP_Z;
                    else                  nzp_d = NZP_P;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q         <= '0;
            bn_q        <= '0;
            d_q         <= '0;
            step_q      <= '0;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            nzp_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            bn_q        <= bn_d;
            d_q         <= d_d;
            step_q      <= step_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            nzp_q       <= nzp_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign D         = d_q;
    assign borrow    = borrow_q;
    assign overflow  = ovf_q;
    assign nzp       = nzp_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: accepted operands push an
// arithmetic-model result; a monitor pops and compares on each result handshake.
module tb_nibble_serial_subtractor;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] D;
    logic        borrow;
    logic        overflow;
    logic [2:0]  nzp;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .D(D),
        .borrow(borrow), .overflow(overflow), .nzp(nzp)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] d;
        logic        brw;
        logic        ovf;
        logic [2:0]  nzp;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   ov_prev = 0;
    bit   chk_rdy = 0;
    bit   rnd_rdy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction and signed range check.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int acc);
        exp_t e;
        int sa, sbv, sd;
        sa    = int'($signed(a));
        sbv   = int'($signed(b));
        sd    = sa - sbv;
        e.d   = 16'((int'(a) - int'(b)) & 16'hFFFF);
        e.brw = (a < b);
        e.ovf = (sd > 32767) || (sd < -32768);
        e.nzp = (e.d == 16'h0) ? 3'b010 : (e.d[15] ? 3'b100 : 3'b001);
        e.acc = acc;
        return e;
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    // Accept observer: handshake completes on the next rising edge.
    always @(negedge Clk) begin
        if (Reset_n && in_valid && in_ready) sb.push_back(model(A, B, cyc + 1));
    end

    // Monitor: latency on out_valid rise, result compare on each drain.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            ov_prev = 0;
            chk_rdy = 0;
        end else begin
            if (chk_rdy) begin
                chk("in_ready_after_drain", in_ready, 1);
                chk_rdy = 0;
            end
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else chk("latency", cyc - sb[0].acc, 4);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("D", D, e.d);
                    chk("borrow", borrow, e.brw);
                    chk("overflow", overflow, e.ovf);
                    chk("nzp", nzp, e.nzp);
                    chk_rdy = 1;
                end
            end
            ov_prev = out_valid;
        end
    end

    // Random consumer backpressure when enabled.
    always @(posedge Clk) begin
        if (rnd_rdy) begin
            #1 out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        @(posedge Clk); #1;
        in_valid = 1'b1; A = a; B = b;
        @(negedge Clk);
        while (!in_ready && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge Clk); #1;
        in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 0, 1);
            sb.delete();
        end
        @(negedge Clk);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state, checked while reset is still asserted.
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_D", D, 0);
        chk("rst_nzp", nzp, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed vectors.
        send(16'h0005, 16'h0003); wait_idle();
        send(16'h0003, 16'h0005); wait_idle();
        send(16'h8000, 16'h0001); wait_idle();
        send(16'h7FFF, 16'hFFFF); wait_idle();
        send(16'h1234, 16'h1234); wait_idle();
        send(16'h0000, 16'h0001); wait_idle();

        // Backpressure in DONE while upstream keeps offering.
        out_ready = 1'b0;
        send(16'h4321, 16'h1111);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge Clk);
                n++;
            end
            chk("bp_valid_seen", out_valid, 1);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
            @(negedge Clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            if (sb.size() == 1) begin
                chk("bp_D_hold", D, sb[0].d);
                chk("bp_nzp_hold", nzp, sb[0].nzp);
            end else chk("bp_queue_depth", sb.size(), 1);
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("bp_no_second_accept", sb.size(), 0);

        // Reset pulse during the second RUN cycle.
        send(16'hABCD, 16'h1234);
        @(posedge Clk); #2;
        Reset_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_D", D, 0);
        chk("abort_nzp", nzp, 0);
        chk("abort_in_ready", in_ready, 1);
        sb.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        send(16'h0100, 16'h0001); wait_idle();

        // Randomized operands with random consumer stalls.
        rnd_rdy = 1;
        for (int i = 0; i < 40; i++) send(pick(), pick());
        @(posedge Clk);
        rnd_rdy = 0;
        #1 out_ready = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
